uart_tx: RTL
============

# uart_tx

Serial transmitter for the APB UART. Sits directly downstream of the TX FIFO, which the register map fills on writes to the data register. Pops one word at a time from a first-word-fall-through FIFO and shifts it out LSB-first as a start/data/optional-parity/stop frame, timed by oversampled baud ticks from baud_generate. Reports tx_busy and tx_ready back to the register map, which uses them for the status and interrupt registers.

## Interface
- DATA_WIDTH, 8, data bits per frame (5..8)
- OVERSAMPLE, 16, baud_tick pulses per bit period (≥2)
- PARITY_EN, 0, 1: insert parity bit after data
- PARITY_ODD, 0, 1: odd parity, 0: even (ignored if PARITY_EN=0)
- STOP_BITS, 1, stop bits per frame (1 or 2)

- PCLK  in  1  clock; one clock domain; all state updates on rising edge
- PRESETn  in  1  reset; synchronous, active-low
- en_sys  in  1  UART system enable; low aborts any frame
- tx_en  in  1  transmit enable; gates new frame starts only
- baud_tick  in  1  single-cycle pulse, OVERSAMPLE per bit
- dout_tx_fifo  in  DATA_WIDTH  FIFO head word, valid while !empty_tx_fifo
- empty_tx_fifo  in  1  FIFO empty
- rd_en_tx_fifo  out  1  pop strobe, combinational
- tx  out  1  serial line, registered, idle high
- tx_busy  out  1  frame in progress, registered
- tx_ready  out  1  one-cycle pulse on frame completion, registered

## Operation
- States: IDLE, START, DATA, PARITY, STOP.
- Start condition: state is IDLE and en_sys && tx_en && !empty_tx_fifo.
  - rd_en_tx_fifo=1 in that same cycle.
  - On that edge: shift register ← dout_tx_fifo, parity ← ^dout (inverted if PARITY_ODD), tick_cnt←0, state→START, tx←0, tx_busy←1.
- Bit period: tick_cnt (width $clog2(OVERSAMPLE)) increments on each baud_tick. The baud_tick where tick_cnt==OVERSAMPLE-1 ends the bit. On that edge tick_cnt←0 and the next bit value is driven on tx.
- START→DATA: tx←shift[0].
- DATA: after each bit, shift right and increment bit_cnt (width $clog2(DATA_WIDTH)). After bit DATA_WIDTH-1 → PARITY (tx←parity) if PARITY_EN, else → STOP (tx←1).
- PARITY→STOP: tx←1.
- STOP: lasts STOP_BITS bit periods; stop_cnt counts them.
- End of the last stop bit:
  - tx_ready←1 for one cycle.
  - If the start condition holds in that cycle: pop, load, →START, tx←0. tx_busy stays 1, so frames run back-to-back with no idle gap.
  - Otherwise: →IDLE, tx_busy←0.
- tx_en falling mid-frame: the current frame completes normally; no new pop.
- en_sys low in any state: next edge → IDLE, tx←1, tx_busy←0, counters←0, no tx_ready pulse. The popped word is discarded.
- baud_tick is ignored in IDLE. Ticks arriving while the FIFO is empty have no effect.
- The empty FIFO is never popped; rd_en_tx_fifo is 0 whenever empty_tx_fifo=1.

## Timing
- Reset (PRESETn=0 at an edge): tx=1, tx_busy=0, tx_ready=0, state IDLE, all counters 0. rd_en_tx_fifo=0 while in reset. Reset mid-frame has the same effect; the frame is truncated.
- Pop latency: rd_en_tx_fifo high in cycle N; tx low and tx_busy high from cycle N+1.
- Frame length: (1 + DATA_WIDTH + PARITY_EN + STOP_BITS) × OVERSAMPLE baud_ticks.
- tx_ready asserts the cycle after the final stop-bit tick, for exactly one cycle.
- In back-to-back operation, the next pop happens in that same cycle.

## Structure
- Shared package uart_pkg holds:
  - tx_state_t enum (IDLE, START, DATA, PARITY, STOP)
  - parity mode constants (PAR_EVEN=0, PAR_ODD=1)
  - default OVERSAMPLE=16
- The receiver reuses the same package.
- Single module, no sub-module. The counters and FSM are small enough to keep flat.

## Test plan
- Reset, then FIFO holds 0x55; OVERSAMPLE=16, baud_tick every cycle → one pop. tx = 0 then 1,0,1,0,1,0,1,0 then 1, each level held 16 cycles. tx_ready pulses at cycle 161 after the pop; tx_busy high for 160 cycles.
- PARITY_EN=1, PARITY_ODD=0, data 0x07 → parity bit 1. With PARITY_ODD=1 → parity bit 0. Frame is 11 bits.
- FIFO holds 0xA3 then 0x3C, tx_en=1 throughout → second pop coincides with the tx_ready pulse. The stop bit of frame 1 is followed directly by the start bit of frame 2. tx_busy never drops between frames.
- tx_en falls during DATA bit 3 of 0xF0 → frame completes with tx_ready. No further pop although FIFO is non-empty.
- en_sys falls during DATA → tx=1 and tx_busy=0 next cycle, no tx_ready. Re-enabling with FIFO holding 0x81 starts a fresh, full frame.
- PRESETn=0 for one cycle mid-STOP → all outputs at reset values next cycle. Empty FIFO → rd_en_tx_fifo never asserts, tx stays 1.

Source files
------------

// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : uart_pkg
//  Purpose  : Shared definitions for the APB UART transmitter and receiver:
//             frame state encoding, parity mode constants and the default
//             baud oversampling ratio.
//  Ports    : none (package)
//  Revision : 1.0  initial release
// ============================================================================
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } tx_state_t;

    localparam bit PAR_EVEN = 1'b0;
    localparam bit PAR_ODD  = 1'b1;

    localparam int DEFAULT_OVERSAMPLE = 16;

endpackage
`default_nettype wire

// File: rtl/uart_tx.sv
`default_nettype none
// ============================================================================
//  Module   : uart_tx
//  Purpose  : UART serial transmitter. Pops words from a first-word-fall-
//             through TX FIFO and shifts them out LSB-first as
//             start / data / optional parity / stop frames, one bit per
//             OVERSAMPLE baud ticks.
//  Ports    : PCLK          - clock
//             PRESETn       - synchronous active-low reset
//             en_sys        - UART enable, low aborts the current frame
//             tx_en         - transmit enable, gates new frame starts only
//             baud_tick     - oversampled baud strobe
//             dout_tx_fifo  - FIFO head word
//             empty_tx_fifo - FIFO empty flag
//             rd_en_tx_fifo - FIFO pop strobe (combinational)
//             tx            - serial line, idle high (registered)
//             tx_busy       - frame in progress (registered)
//             tx_ready      - one-cycle pulse at frame completion (registered)
//  Revision : 1.0  initial release
// ============================================================================
module uart_tx
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int OVERSAMPLE = DEFAULT_OVERSAMPLE,
    parameter bit PARITY_EN  = 1'b0,
    parameter bit PARITY_ODD = PAR_EVEN,
    parameter int STOP_BITS  = 1
) (
    input  logic                  PCLK,
    input  logic                  PRESETn,
    input  logic                  en_sys,
    input  logic                  tx_en,
    input  logic                  baud_tick,
    input  logic [DATA_WIDTH-1:0] dout_tx_fifo,
    input  logic                  empty_tx_fifo,
    output logic                  rd_en_tx_fifo,
    output logic                  tx,
    output logic                  tx_busy,
    output logic                  tx_ready
);

    localparam int TICK_W = $clog2(OVERSAMPLE);
    localparam int BIT_W  = $clog2(DATA_WIDTH);

    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(OVERSAMPLE - 1);
    localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_WIDTH - 1);
    localparam logic              STOP_LAST = 1'(STOP_BITS - 1);

    tx_state_t             r_state,    w_state;
    logic [DATA_WIDTH-1:0] r_shift,    w_shift;
    logic                  r_parity,   w_parity;
    logic [TICK_W-1:0]     r_tick_cnt, w_tick_cnt;
    logic [BIT_W-1:0]      r_bit_cnt,  w_bit_cnt;
    logic                  r_stop_cnt, w_stop_cnt;
    logic                  r_tx,       w_tx;
    logic                  r_busy,     w_busy;
    logic                  r_ready,    w_ready;

    logic w_start;
    logic w_bit_end;
    logic w_load;
    logic w_rd_en;

    assign w_start   = en_sys && tx_en && !empty_tx_fifo;
    assign w_bit_end = baud_tick && (r_tick_cnt == TICK_LAST);

    always_comb begin
        w_state    = r_state;
        w_shift    = r_shift;
        w_parity   = r_parity;
        w_tick_cnt = r_tick_cnt;
        w_bit_cnt  = r_bit_cnt;
        w_stop_cnt = r_stop_cnt;
        w_tx       = r_tx;
        w_busy     = r_busy;
        w_ready    = 1'b0;
        w_load     = 1'b0;
        w_rd_en    = 1'b0;

        if (!en_sys) begin
            // Abort: drop the frame silently, the popped word is lost.
            w_state    = IDLE;
            w_tick_cnt = '0;
            w_bit_cnt  = '0;
            w_stop_cnt = 1'b0;
            w_tx       = 1'b1;
            w_busy     = 1'b0;
        end else begin
            if ((r_state != IDLE) && baud_tick) begin
                w_tick_cnt = w_bit_end ? '0 : r_tick_cnt + TICK_W'(1);
            end

            case (r_state)
                IDLE: begin
                    w_load = w_start;
                end
                START: begin
                    if (w_bit_end) begin
                        w_state   = DATA;
                        w_bit_cnt = '0;
                        w_tx      = r_shift[0];
                    end
                end
                DATA: begin
                    if (w_bit_end) begin
                        w_shift = {1'b0, r_shift[DATA_WIDTH-1:1]};
                        if (r_bit_cnt == BIT_LAST) begin
                            w_bit_cnt = '0;
                            if (PARITY_EN) begin
                                w_state = PARITY;
                                w_tx    = r_parity;
                            end else begin
                                w_state    = STOP;
                                w_stop_cnt = 1'b0;
                                w_tx       = 1'b1;
                            end
                        end else begin
                            w_bit_cnt = r_bit_cnt + BIT_W'(1);
                            // Bit 1 of the pre-shift word is the next one out.
                            w_tx      = r_shift[1];
                        end
                    end
                end
                PARITY: begin
                    if (w_bit_end) begin
                        w_state    = STOP;
                        w_stop_cnt = 1'b0;
                        w_tx       = 1'b1;
                    end
                end
                STOP: begin
                    if (w_bit_end) begin
                        if (r_stop_cnt == STOP_LAST) begin
                            w_ready = 1'b1;
                            if (w_start) begin
                                // Back-to-back: next start bit follows the stop bit.
                                w_load = 1'b1;
                            end else begin
                                w_state = IDLE;
                                w_busy  = 1'b0;
                            end
                        end else begin
                            w_stop_cnt = r_stop_cnt + 1'b1;
                        end
                    end
                end
                default: begin
                    w_state = IDLE;
                end
            endcase

            if (w_load) begin
                w_rd_en    = 1'b1;
                w_state    = START;
                w_shift    = dout_tx_fifo;
                w_parity   = (^dout_tx_fifo) ^ (PARITY_ODD == PAR_ODD);
                w_tick_cnt = '0;
                w_bit_cnt  = '0;
                w_stop_cnt = 1'b0;
                w_tx       = 1'b0;
                w_busy     = 1'b1;
            end
        end
    end

    always_ff @(posedge PCLK) begin
        if (!PRESETn) begin
            r_state    <= IDLE;
            r_shift    <= '0;
            r_parity   <= 1'b0;
            r_tick_cnt <= '0;
            r_bit_cnt  <= '0;
            r_stop_cnt <= 1'b0;
            r_tx       <= 1'b1;
            r_busy     <= 1'b0;
            r_ready    <= 1'b0;
        end else begin
            r_state    <= w_state;
            r_shift    <= w_shift;
            r_parity   <= w_parity;
            r_tick_cnt <= w_tick_cnt;
            r_bit_cnt  <= w_bit_cnt;
            r_stop_cnt <= w_stop_cnt;
            r_tx       <= w_tx;
            r_busy     <= w_busy;
            r_ready    <= w_ready;
        end
    end

    // The pop strobe is combinational, so it must be masked during reset.
    assign rd_en_tx_fifo = w_rd_en && PRESETn;
    assign tx            = r_tx;
    assign tx_busy       = r_busy;
    assign tx_ready      = r_ready;

endmodule
`default_nettype wire
